// File: rtl/audio_mixer.sv
// Four-channel APU mixer: snapshots the channel DAC codes on each divider tick,
// accumulates them over four cycles, scales by master volume and holds the result.
module audio_mixer #(
  parameter int SAMPLE_DIV = 521
) (
  input  logic        clock25mhz,
  input  logic        resetn,
  input  logic [3:0]  ch1,
  input  logic [3:0]  ch2,
  input  logic [3:0]  ch3,
  input  logic [3:0]  ch4,
  input  logic [3:0]  dac_en,
  input  logic [3:0]  ch_en,
  input  logic [2:0]  master_vol,
  output logic [23:0] sample,
  output logic        sample_valid,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [15:0]       div_reg;
  logic              tick;
  logic [1:0]        state_reg;
  logic [1:0]        idx_reg;
  logic [3:0]        ch_in [4];
  logic [3:0]        ch_snap_reg [4];
  logic [3:0]        dac_snap_reg;
  logic [3:0]        en_snap_reg;
  logic [2:0]        vol_reg;
  logic signed [7:0] acc_reg;
  logic signed [9:0] prod_reg;
  logic              load;

  assign ch_in[0] = ch1;
  assign ch_in[1] = ch2;
  assign ch_in[2] = ch3;
  assign ch_in[3] = ch4;

  assign tick = (div_reg == 16'(SAMPLE_DIV - 1));
  assign load = (state_reg == IDLE) && tick;
  assign busy = (state_reg != IDLE);

  always_ff @(posedge clock25mhz or negedge resetn) begin
    if (!resetn) begin
      div_reg <= '0;
    end else if (tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 16'd1;
    end
  end

  // Inputs are captured only at the tick so later changes cannot disturb a mix.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
      always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
          ch_snap_reg[gi] <= '0;
        end else if (load) begin
          ch_snap_reg[gi] <= ch_in[gi];
        end
      end
    end
  endgenerate

  // Shared adder operand: 2*ch - 15 maps the unipolar code onto -15..+15.
  logic [3:0]        cur_ch;
  logic              ch_on;
  logic signed [5:0] term;
  logic signed [7:0] addend;
  logic [3:0]        gain;
  logic signed [12:0] prod_full;

  assign cur_ch    = ch_snap_reg[idx_reg];
  assign ch_on     = dac_snap_reg[idx_reg] & en_snap_reg[idx_reg];
  assign term      = $signed({1'b0, cur_ch, 1'b0}) - 6'sd15;
  assign addend    = ch_on ? {{2{term[5]}}, term} : 8'sd0;
  assign gain      = {1'b0, vol_reg} + 4'd1;
  assign prod_full = acc_reg * $signed({1'b0, gain});

  always_ff @(posedge clock25mhz or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      dac_snap_reg <= '0;
      en_snap_reg  <= '0;
      vol_reg      <= '0;
      acc_reg      <= '0;
      prod_reg     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            dac_snap_reg <= dac_en;
            en_snap_reg  <= ch_en;
            vol_reg      <= master_vol;
            acc_reg      <= '0;
            idx_reg      <= '0;
            state_reg    <= ACC;
          end
        end
        ACC: begin
          acc_reg <= acc_reg + addend;
          idx_reg <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_reg <= SCALE;
          end
        end
        SCALE: begin
          prod_reg  <= prod_full[9:0];
          state_reg <= OUT;
        end
        default: begin
          sample       <= {prod_reg[9], prod_reg, 13'b0};
          sample_valid <= 1'b1;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

endmodule
